sensor_scan_ctrl: RTL
=====================

// Module: sensor_scan_ctrl
// PURPOSE
//   Sequencer on the select side of the 8:1 sensor mux: drives the 3-bit address, waits for the
//   mux path to settle, captures the selected 8-bit sample into one of 8 channel registers
//   (demux direction), and flags channels above a threshold. Supports single-sweep and
//   continuous scanning, with a registered readback port.
// PARAMETERS
//   DATA_W         8   sample width (mux data width)
//   SETTLE_CYCLES  2   cycles the address is held before capture; legal range 1..15
// PORTS
//   clk         in   1       system clock, all logic on rising edge
//   rst         in   1       synchronous, active-high reset
//   start       in   1       level-sampled; starts one sweep when idle
//   continuous  in   1       1 = restart sweep after channel 7 without returning to idle
//   address     out  3       mux select, registered
//   mux_in      in   DATA_W  selected sensor data returned by the mux (combinational path)
//   threshold   in   DATA_W  unsigned alarm threshold
//   busy        out  1       1 while a sweep is in progress
//   scan_done   out  1       one-cycle pulse after channel 7 is captured
//   ch_valid    out  8       bit i set once channel i has been captured since reset
//   alarm       out  8       bit i = (last sample of ch i > threshold), unsigned, strict
//   rd_sel      in   3       channel register to read back
//   rd_data     out  DATA_W  registered ch_reg[rd_sel], 1-cycle latency
// BEHAVIOUR
//   Reset (rst=1 at an edge): state IDLE, address 0, busy 0, scan_done 0, ch_valid 0, alarm 0,
//     rd_data 0, all ch_reg 0, settle counter 0. Reset mid-sweep aborts immediately; no
//     partial results are kept.
//   FSM states IDLE, SETTLE, CAPTURE; busy = (state != IDLE), registered with the state.
//   IDLE: if start | continuous -> address<=0, cnt<=0, SETTLE. Otherwise address holds.
//   SETTLE: cnt increments each cycle; at cnt==SETTLE_CYCLES-1 -> CAPTURE. Lasts exactly
//     SETTLE_CYCLES cycles.
//   CAPTURE (one cycle): ch_reg[address]<=mux_in; ch_valid[address]<=1;
//     alarm[address]<=(mux_in>threshold) with the threshold value of this cycle.
//     address<7: address<=address+1, cnt<=0, SETTLE.
//     address==7: scan_done<=1 next cycle; continuous=1 -> address<=0, SETTLE (busy stays 1);
//     else -> IDLE (busy 0 in the same cycle scan_done is 1).
//   Timing: per channel SETTLE_CYCLES+1 cycles; scan_done asserts 8*(SETTLE_CYCLES+1) cycles
//     after the edge at which start was sampled in IDLE.
//   start while busy: ignored, no queuing. continuous dropped mid-sweep: current sweep
//     completes, then IDLE. alarm bits for uncaptured channels keep their previous value.
//   rd_data<=ch_reg[rd_sel] every cycle; if rd_sel equals the channel captured in the same
//     cycle, the pre-capture value is returned (new value visible one cycle later).
//   threshold changes affect only subsequent captures; alarm is never recomputed retroactively.
// TESTING  (SETTLE_CYCLES=2; mux model returns 8'h10+address)
//   1 rst then 1-cycle start -> address 0,0,0,1,1,1..7; scan_done single pulse 24 cycles after
//     start edge; ch_reg = 10..17; ch_valid=8'hFF; busy low with scan_done.
//   2 threshold=8'h14, one sweep -> alarm=8'b1110_0000 (ch4=0x14 equal, not flagged).
//   3 start re-pulsed at cycle 10 of a sweep -> ignored; exactly one scan_done at cycle 24.
//   4 continuous held high -> scan_done every 24 cycles, address wraps 7->0 with busy stuck 1;
//     drop continuous mid-sweep -> sweep finishes, IDLE.
//   5 rst during SETTLE of channel 3 -> next cycle all outputs 0, address 0, IDLE; new start
//     then completes a full sweep normally.
//   6 after sweep, rd_sel=5 -> rd_data=8'h15 one cycle later; rd_sel=ch under capture -> old
//     value, then new value next cycle.

Source files
------------

// File: rtl/sensor_scan_ctrl.sv
// Sensor mux sequencer: steps the 8:1 select, waits for settling,
// captures each channel, flags threshold alarms, registered readback.
module sensor_scan_ctrl #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic [2:0]        address,
  input  logic [DATA_W-1:0] mux_in,
  input  logic [DATA_W-1:0] threshold,
  output logic              busy,
  output logic              scan_done,
  output logic [7:0]        ch_valid,
  output logic [7:0]        alarm,
  input  logic [2:0]        rd_sel,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic [2:0]        addr_n;
  logic              done_n;
  logic              cap;
  logic [DATA_W-1:0] ch_reg [8];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = address;
    done_n  = 1'b0;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start | continuous) begin
          addr_n  = 3'd0;
          cnt_n   = 4'd0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        cnt_n = cnt + 4'd1;
        if (cnt == CNT_LAST) state_n = CAPTURE;
      end
      CAPTURE: begin
        cap   = 1'b1;
        cnt_n = 4'd0;
        if (address != 3'd7) begin
          addr_n  = address + 3'd1;
          state_n = SETTLE;
        end else begin
          done_n = 1'b1;
          if (continuous) begin
            addr_n  = 3'd0;
            state_n = SETTLE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      address   <= 3'd0;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_n;
      address   <= addr_n;
      cnt       <= cnt_n;
      busy      <= (state_n != IDLE);
      scan_done <= done_n;
    end
  end

  // Readback samples before the capture write lands, so a same-cycle
  // capture of rd_sel shows the old value first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_valid <= 8'd0;
      alarm    <= 8'd0;
      rd_data  <= '0;
      for (int i = 0; i < 8; i++) ch_reg[i] <= '0;
    end else begin
      rd_data <= ch_reg[rd_sel];
      if (cap) begin
        ch_reg[address]   <= mux_in;
        ch_valid[address] <= 1'b1;
        alarm[address]    <= (mux_in > threshold);
      end
    end
  end

endmodule
